// File: rtl/hs_math_seq_pkg.sv
// Shared types and helpers for the sequential math evaluators.
// HS_MATH_GCD_LCM_EN: when defined, the GCD unit also produces the LCM.
package hs_math_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_ODDA  = 3'd2,
    ST_LOOP  = 3'd3,
    ST_FINAL = 3'd4,
    ST_DIV   = 3'd5,
    ST_MUL   = 3'd6,
    ST_DONE  = 3'd7
  } gcd_state_e;

  // Worst-case accept-to-out_valid latency of hs_math_gcd_lcm_seq.
  function automatic int gcd_max_latency(input int width);
`ifdef HS_MATH_GCD_LCM_EN
    return 4 * width + 5;
`else
    return 3 * width + 4;
`endif
  endfunction

endpackage

// File: rtl/hs_math_div_seq.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH cycles.
// done is high during the final iteration cycle; quotient and remainder
// hold the final result from the following cycle until the next start.
module hs_math_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   trial_rem;
  logic [WIDTH:0]   trial_diff;

  // Partial remainder shifted left by one with the next dividend bit.
  assign trial_rem  = {rem_q, quo_q[WIDTH-1]};
  assign trial_diff = trial_rem - {1'b0, dvs_q};

  // Load on start, then one shift/subtract step per cycle until the count expires.
  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (start) begin
      cnt_d = CW'(WIDTH);
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (!trial_diff[WIDTH]) begin
        rem_d = trial_diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial_rem[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hs_math_gcd_lcm_seq.sv
// Binary (Stein) GCD unit with valid/ready handshakes, one operation in flight.
// HS_MATH_GCD_LCM_EN: when defined, adds a divider and multiplier so out_lcm
// carries lcm(A,B); otherwise out_lcm is tied to zero.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for an operand pair, in_ready high
// SHIFT  | strip common factors of two from a and b, counting in k
// ODDA   | strip remaining factors of two from a
// LOOP   | a odd: halve even b, or replace (a,b) by (min, |a-b|)
// FINAL  | gcd = a << k
// DIV    | q = a0 / gcd, WIDTH cycles
// MUL    | lcm = q * b0
// DONE   | result presented, out_valid high
module hs_math_gcd_lcm_seq
  import hs_math_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_gcd,
  output logic [2*WIDTH-1:0] out_lcm
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;

  logic             a_ge_b;
  logic [WIDTH-1:0] sub_big, sub_small, sub_diff;
  logic [WIDTH-1:0] gcd_full;

  // One shared subtractor: larger minus smaller gives |a-b|.
  assign a_ge_b    = (a_q >= b_q);
  assign sub_big   = a_ge_b ? a_q : b_q;
  assign sub_small = a_ge_b ? b_q : a_q;
  assign sub_diff  = sub_big - sub_small;
  // Restoring the common power of two cannot overflow: it divides both operands.
  assign gcd_full  = a_q << k_q;

`ifdef HS_MATH_GCD_LCM_EN
  logic [WIDTH-1:0]   a0_q, a0_d;
  logic [WIDTH-1:0]   b0_q, b0_d;
  logic [2*WIDTH-1:0] lcm_q, lcm_d;
  logic               div_start;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;

  // Divisor is taken straight from the shifter so the divide starts as gcd is registered.
  hs_math_div_seq #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a0_q),
    .divisor  (gcd_full),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );
`endif

  // Next-state and datapath updates for the GCD sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    gcd_d   = gcd_q;
`ifdef HS_MATH_GCD_LCM_EN
    a0_d      = a0_q;
    b0_d      = b0_q;
    lcm_d     = lcm_q;
    div_start = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          k_d   = '0;
          gcd_d = '0;
`ifdef HS_MATH_GCD_LCM_EN
          a0_d  = in_a;
          b0_d  = in_b;
          lcm_d = '0;
`endif
          if ((in_a == '0) || (in_b == '0)) begin
            gcd_d   = in_a | in_b;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = ST_ODDA;
        end
      end
      ST_ODDA: begin
        if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else begin
          state_d = ST_LOOP;
        end
      end
      ST_LOOP: begin
        if (b_q == '0) begin
          state_d = ST_FINAL;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else begin
          a_d = sub_small;
          b_d = sub_diff;
        end
      end
      ST_FINAL: begin
        gcd_d = gcd_full;
`ifdef HS_MATH_GCD_LCM_EN
        div_start = 1'b1;
        state_d   = ST_DIV;
`else
        state_d   = ST_DONE;
`endif
      end
      ST_DIV: begin
`ifdef HS_MATH_GCD_LCM_EN
        if (div_done) begin
          state_d = ST_MUL;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_MUL: begin
`ifdef HS_MATH_GCD_LCM_EN
        lcm_d   = (2*WIDTH)'(div_quo) * (2*WIDTH)'(b0_q);
        state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      gcd_q   <= '0;
`ifdef HS_MATH_GCD_LCM_EN
      a0_q    <= '0;
      b0_q    <= '0;
      lcm_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      gcd_q   <= gcd_d;
`ifdef HS_MATH_GCD_LCM_EN
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      lcm_q   <= lcm_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_gcd   = gcd_q;
`ifdef HS_MATH_GCD_LCM_EN
  assign out_lcm   = lcm_q;
`else
  assign out_lcm   = '0;
`endif

endmodule

// File: tb/tb_hs_math_gcd_lcm_seq.sv
// Scoreboard bench for hs_math_gcd_lcm_seq (WIDTH=32).
// HS_MATH_GCD_LCM_EN selects whether LCM results are expected.
module tb_hs_math_gcd_lcm_seq;

  localparam int W = 32;
`ifdef HS_MATH_GCD_LCM_EN
  localparam bit LCM_EN = 1'b1;
`else
  localparam bit LCM_EN = 1'b0;
`endif
  localparam int LAT_BOUND = 3 * W + 4 + (LCM_EN ? W + 1 : 0);
  localparam int LAT_LIMIT = LAT_BOUND + 20;

  typedef struct packed {
    logic [W-1:0]   g;
    logic [2*W-1:0] l;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_gcd;
  logic [2*W-1:0] out_lcm;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  hs_math_gcd_lcm_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_gcd  (out_gcd),
    .out_lcm  (out_lcm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a;
    logic [W-1:0] y = b;
    logic [W-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [2*W-1:0] ref_lcm(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] g;
    if (!LCM_EN || a == '0 || b == '0) return '0;
    g = ref_gcd(a, b);
    return (2*W)'(a / g) * (2*W)'(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected result, then hand the pair over on the input handshake.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    e.g = ref_gcd(a, b);
    e.l = ref_lcm(a, b);
    exp_q.push_back(e);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < LAT_LIMIT) begin
      tick();
      n++;
    end
    tests_run++;
    if (!in_ready) begin
      tests_failed++;
      $display("FAIL send_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Full transaction: send, wait for result, compare against scoreboard, release.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name,
                       output int lat);
    exp_t e;
    send_op(a, b);
    lat = 1;
    while (!out_valid && lat < LAT_LIMIT) begin
      tick();
      lat++;
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_valid_timeout: out_valid=%0b required 1", name, out_valid);
    end
    tests_run++;
    if (lat > LAT_BOUND) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d required <= %0d", name, lat, LAT_BOUND);
    end
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_scoreboard_empty: size=0 required >0", name);
    end else begin
      e = exp_q.pop_front();
      tests_run++;
      if (out_gcd !== e.g) begin
        tests_failed++;
        $display("FAIL %s_gcd: got %h required %h", name, out_gcd, e.g);
      end
      tests_run++;
      if (out_lcm !== e.l) begin
        tests_failed++;
        $display("FAIL %s_lcm: got %h required %h", name, out_lcm, e.l);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_release: in_ready=%0b out_valid=%0b required 1/0", name, in_ready,
               out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %0b required 0", out_valid);
    end
    tests_run++;
    if (out_gcd !== '0 || out_lcm !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: gcd=%h lcm=%h required 0/0", out_gcd, out_lcm);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    do_op(32'd12, 32'd18, "g12_18", lat);
    do_op(32'h8000_0000, 32'h4000_0000, "pow2", lat);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, "max", lat);
    do_op(32'd17, 32'd31, "primes", lat);
    do_op(32'd1, 32'd1, "ones", lat);
  endtask

  task automatic test_zero();
    int lat;
    do_op(32'd0, 32'd7, "zero_a", lat);
    tests_run++;
    if (lat != 1) begin
      tests_failed++;
      $display("FAIL zero_a_latency_exact: got %0d required 1", lat);
    end
    do_op(32'd0, 32'd0, "zero_both", lat);
    tests_run++;
    if (lat != 1) begin
      tests_failed++;
      $display("FAIL zero_both_latency_exact: got %0d required 1", lat);
    end
    do_op(32'd9, 32'd0, "zero_b", lat);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    int   lat2;
    e.g = 32'd6;
    e.l = LCM_EN ? 64'd36 : 64'd0;
    send_op(32'd12, 32'd18);
    lat = 1;
    while (!out_valid && lat < LAT_LIMIT) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_handshake_%0d: out_valid=%0b in_ready=%0b required 1/0", i,
                 out_valid, in_ready);
      end
      tests_run++;
      if (out_gcd !== e.g || out_lcm !== e.l) begin
        tests_failed++;
        $display("FAIL bp_stable_%0d: gcd=%h lcm=%h required %h/%h", i, out_gcd, out_lcm,
                 e.g, e.l);
      end
    end
    in_valid = 1'b0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    tests_run++;
    if (out_gcd !== e.g || out_lcm !== e.l) begin
      tests_failed++;
      $display("FAIL bp_result: gcd=%h lcm=%h required %h/%h", out_gcd, out_lcm, e.g, e.l);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0/1", out_valid,
               in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_no_capture_%0d: out_valid=%0b in_ready=%0b required 0/1", i,
                 out_valid, in_ready);
      end
    end
    do_op(32'd17, 32'd31, "bp_next", lat2);
  endtask

  task automatic test_reset_mid();
    int lat;
    send_op(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_state: in_ready=%0b out_valid=%0b required 1/0", in_ready,
               out_valid);
    end
    tests_run++;
    if (out_gcd !== '0 || out_lcm !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: gcd=%h lcm=%h required 0/0", out_gcd, out_lcm);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_no_result_%0d: out_valid=%0b required 0", i, out_valid);
      end
    end
    do_op(32'd48, 32'd36, "rstmid_next", lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] g, a, b;
    for (int i = 0; i < 6; i++) begin
      g = W'($urandom_range(1, 255));
      a = g * W'($urandom_range(1, 1000));
      b = g * W'($urandom_range(1, 1000));
      do_op(a, b, "b2b", lat);
    end
    do_op(32'd1000, 32'd1000, "b2b_equal", lat);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hs_math_gcd_lcm_seq.md
Name: hs_math_gcd_lcm_seq

Overview:
- Multi-cycle, parametrised-width GCD unit using the binary (Stein) algorithm, with an optional LCM path.
- Accepts operand pairs over a valid/ready input handshake and returns results over a valid/ready output handshake.
- Single-context, non-pipelined: one operation in flight at a time.
- Sits beside the shared math package as the hardware evaluator for runtime operands, e.g. clock-ratio and stride computation.

Parameters:
- WIDTH, 32, operand and GCD width in bits; must be ≥2.
- KW, $clog2(WIDTH+1), width of the common-factor-of-two counter (derived; do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_gcd  out  WIDTH  gcd(A,B).
- out_lcm  out  2*WIDTH  lcm(A,B); zero when feature compiled out.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, in_ready=1, out_valid=0, out_gcd=0, out_lcm=0. All internal registers cleared.
- Reset mid-operation: the operation is discarded and no result is produced.
- Handshake:
  - in_ready=1 only in IDLE.
  - Transfer occurs on in_valid&&in_ready at a clk edge; operands are captured then. in_a/in_b are ignored at all other times.
  - out_valid=1 only in DONE. out_gcd/out_lcm stay stable while out_valid=1 and out_ready=0.
  - A transfer on out_valid&&out_ready returns the block to IDLE. in_ready rises the following cycle, so there is no same-cycle input/output overlap.
- States: IDLE, SHIFT, ODDA, LOOP, FINAL, DIV, MUL, DONE.
- IDLE, on accept:
  - Latch a=in_a, b=in_b, a0=in_a, b0=in_b, k=0.
  - If a==0 or b==0: gcd=a|b, lcm=0, go to DONE (out_valid the next cycle).
  - Otherwise go to SHIFT.
- SHIFT: if a[0]==0 and b[0]==0, then a>>=1, b>>=1, k++. Else go to ODDA.
- ODDA: if a[0]==0, a>>=1. Else go to LOOP.
- LOOP (a always odd here):
  - b==0: go to FINAL.
  - b[0]==0: b>>=1.
  - Otherwise: a<=min(a,b), b<=|a-b|, using one WIDTH-bit subtractor and a comparator. No overflow is possible.
- FINAL: gcd_r <= a<<k, which fits in WIDTH. Go to DIV if the feature is enabled, else DONE.
- DIV: restoring division q=a0/gcd_r, 1 quotient bit per cycle, exactly WIDTH cycles. The remainder is always 0 and is discarded.
- MUL: lcm_r <= q*b0, 2*WIDTH-bit result, single cycle. Cannot overflow because lcm ≤ a0*b0. Then go to DONE.
- Latency (accept to out_valid):
  - Zero operand: 1 cycle.
  - Otherwise at most 3*WIDTH+4 cycles without the feature.
  - Add WIDTH+1 cycles with the feature.
- out_gcd/out_lcm are registered and driven from gcd_r/lcm_r.

Optional Feature:
- Macro: HS_MATH_GCD_LCM_EN.
- Defined:
  - DIV and MUL states, divider and multiplier are present.
  - out_lcm carries lcm, or 0 if either operand is 0.
- Undefined:
  - FINAL goes directly to DONE.
  - out_lcm is tied to 0.
  - No divider or multiplier logic is synthesised.
  - The port list is unchanged.

Decomposition:
- Package hs_math_seq_pkg holds:
  - typedef enum logic [2:0] gcd_state_e with the eight states above;
  - localparam helper gcd_max_latency(width).
- Sub-module hs_math_div_seq (WIDTH param): restoring divider with start/done pulses, dividend/divisor in, quotient/remainder out.
  - Instantiated only under HS_MATH_GCD_LCM_EN.
  - Reusable by later sequential math blocks.

Test Plan:
- WIDTH=32, (12,18) -> out_gcd=6, out_lcm=36 (feature on) / 0 (feature off); latency ≤ bound.
- (0,7) -> out_gcd=7, out_lcm=0, out_valid exactly 1 cycle after accept. (0,0) -> out_gcd=0, out_lcm=0.
- (0x80000000, 0x40000000) -> out_gcd=0x40000000, out_lcm=0x80000000; exercises the k counter to 30.
- (0xFFFFFFFF, 0xFFFFFFFE) -> out_gcd=1, out_lcm=0xFFFFFFFD00000002. Also (17,31) -> gcd 1, lcm 527.
- out_ready held low for 5 cycles in DONE with in_valid=1 and changing operands -> out_valid and outputs stable, in_ready=0, new operands not captured; result transfers on the first out_ready=1.
- rst_n pulsed low during LOOP -> next cycle IDLE, in_ready=1, out_valid=0; a following (48,36) request returns gcd 12, lcm 144.
